// File: rtl/board_frame_sequencer.sv
// Purpose: owns the working and display copies of the 8x8 chessboard and serialises edits from init, move, set and cursor requesters.
// Latency: init/set/cursor ack 1 cycle after grant, move ack 2 cycles after grant (1 when rejected or a no-op); commit lands 2 cycles after a dirty vblank rise.
// Backpressure: one request granted per idle cycle (commit > init > move > set > cursor); requesters hold req until their one-cycle ack.
module board_frame_sequencer #(
    parameter int SQ_W = 12,
    parameter int N_SQ = 64
) (
    input  logic                   pclk,
    input  logic                   rstn,
    input  logic                   vblank,
    input  logic                   init_req,
    input  logic                   mv_req,
    input  logic [5:0]             mv_src,
    input  logic [5:0]             mv_dst,
    input  logic                   set_req,
    input  logic [5:0]             set_pos,
    input  logic [4:0]             set_piece,
    input  logic                   cur_req,
    input  logic                   cur_en,
    input  logic [5:0]             cur_pos,
    input  logic                   cur_color,
    output logic [N_SQ*SQ_W-1:0]   board_data,
    output logic                   busy,
    output logic                   init_ack,
    output logic                   mv_ack,
    output logic                   set_ack,
    output logic                   cur_ack,
    output logic                   mv_err,
    output logic                   commit_pulse
);

    localparam int BW = N_SQ * SQ_W;
    localparam int IW = $clog2(BW);

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MV_CHK,
        S_MV_WR,
        S_SET,
        S_CUR,
        S_COMMIT
    } state_t;

    // Back-rank piece type by column: rook, knight, bishop, queen, king, bishop, knight, rook.
    function automatic logic [2:0] f_back_type(input int c);
        logic [2:0] t;
        case (c)
            0, 7:    t = 3'b101;
            1, 6:    t = 3'b100;
            2, 5:    t = 3'b011;
            3:       t = 3'b010;
            4:       t = 3'b001;
            default: t = 3'b000;
        endcase
        return t;
    endfunction

    // Starting position: black on rows 0/1, white on rows 6/7, no cursor.
    function automatic logic [BW-1:0] f_init_board();
        logic [BW-1:0] b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[idx_t'(c * SQ_W)        +: 5] = {2'b11, f_back_type(c)};
            b[idx_t'((8 + c) * SQ_W)  +: 5] = 5'b11110;
            b[idx_t'((48 + c) * SQ_W) +: 5] = 5'b10110;
            b[idx_t'((56 + c) * SQ_W) +: 5] = {2'b10, f_back_type(c)};
        end
        return b;
    endfunction

    // Bit offset of a square's field inside the packed board.
    function automatic idx_t f_base(input logic [5:0] p);
        return idx_t'(p) * idx_t'(SQ_W);
    endfunction

    localparam logic [BW-1:0] INIT_BOARD = f_init_board();

    state_t          r_state;
    state_t          w_next;
    logic [BW-1:0]   r_work;
    logic [BW-1:0]   r_disp;
    logic            r_cur_vld;
    logic [5:0]      r_cur_at;
    logic            r_dirty;
    logic            r_commit_pend;
    logic            r_vblank_d;
    logic            r_commit_pulse;

    // Operands captured at grant so a requester changing inputs mid-operation cannot tear an edit.
    logic [5:0]      r_mv_src;
    logic [5:0]      r_mv_dst;
    logic [5:0]      r_set_pos;
    logic [4:0]      r_set_piece;
    logic            r_cur_en;
    logic [5:0]      r_cur_pos;
    logic            r_cur_color;
    logic [4:0]      r_src_pc;

    logic [4:0]      w_src_pc;
    logic            w_edit_done;
    logic            w_vb_rise;
    logic            w_vb_fall;
    logic            w_init_ack;
    logic            w_mv_ack;
    logic            w_mv_err;
    logic            w_set_ack;
    logic            w_cur_ack;

    assign w_src_pc    = r_work[f_base(r_mv_src) +: 5];
    assign w_vb_rise   = vblank & ~r_vblank_d;
    assign w_vb_fall   = ~vblank & r_vblank_d;
    assign w_edit_done = (r_state == S_INIT) || (r_state == S_MV_WR) ||
                         (r_state == S_SET)  || (r_state == S_CUR);

    // State register.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and per-state acknowledge decode.
    always_comb begin
        w_next     = r_state;
        w_init_ack = 1'b0;
        w_mv_ack   = 1'b0;
        w_mv_err   = 1'b0;
        w_set_ack  = 1'b0;
        w_cur_ack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_commit_pend)  w_next = S_COMMIT;
                else if (init_req)  w_next = S_INIT;
                else if (mv_req)    w_next = S_MV_CHK;
                else if (set_req)   w_next = S_SET;
                else if (cur_req)   w_next = S_CUR;
            end
            S_INIT: begin
                w_init_ack = 1'b1;
                w_next     = S_IDLE;
            end
            S_MV_CHK: begin
                if (!w_src_pc[4]) begin
                    w_mv_ack = 1'b1;
                    w_mv_err = 1'b1;
                    w_next   = S_IDLE;
                end else if (r_mv_src == r_mv_dst) begin
                    w_mv_ack = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_next   = S_MV_WR;
                end
            end
            S_MV_WR: begin
                w_mv_ack = 1'b1;
                w_next   = S_IDLE;
            end
            S_SET: begin
                w_set_ack = 1'b1;
                w_next    = S_IDLE;
            end
            S_CUR: begin
                w_cur_ack = 1'b1;
                w_next    = S_IDLE;
            end
            S_COMMIT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch request operands every idle cycle; the grant cycle's values are the ones kept.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            r_mv_src    <= '0;
            r_mv_dst    <= '0;
            r_set_pos   <= '0;
            r_set_piece <= '0;
            r_cur_en    <= 1'b0;
            r_cur_pos   <= '0;
            r_cur_color <= 1'b0;
            r_src_pc    <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_mv_src    <= mv_src;
                r_mv_dst    <= mv_dst;
                r_set_pos   <= set_pos;
                r_set_piece <= set_piece;
                r_cur_en    <= cur_en;
                r_cur_pos   <= cur_pos;
                r_cur_color <= cur_color;
            end
            if (r_state == S_MV_CHK) begin
                r_src_pc <= w_src_pc;
            end
        end
    end

    // Working copy and cursor record: all edits land here, never directly on the display.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            r_work    <= INIT_BOARD;
            r_cur_vld <= 1'b0;
            r_cur_at  <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_work    <= INIT_BOARD;
                    r_cur_vld <= 1'b0;
                end
                S_MV_WR: begin
                    // Only the piece bits travel; cursor bits stay with their square.
                    r_work[f_base(r_mv_dst) +: 5] <= r_src_pc;
                    r_work[f_base(r_mv_src) +: 5] <= 5'b00000;
                end
                S_SET: begin
                    r_work[f_base(r_set_pos) +: 5] <= r_set_piece;
                end
                S_CUR: begin
                    // Clear first, then set: a repeat on the same square ends with the new colour.
                    if (r_cur_vld) begin
                        r_work[f_base(r_cur_at) + idx_t'(8) +: 2] <= 2'b00;
                    end
                    if (r_cur_en) begin
                        r_work[f_base(r_cur_pos) + idx_t'(8) +: 2] <= {r_cur_color, 1'b1};
                        r_cur_at <= r_cur_pos;
                    end
                    r_cur_vld <= r_cur_en;
                end
                default: begin
                end
            endcase
        end
    end

    // Display copy: whole-board snapshot of the working copy, taken only in COMMIT.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            r_disp         <= INIT_BOARD;
            r_commit_pulse <= 1'b0;
        end else begin
            r_commit_pulse <= (r_state == S_COMMIT);
            if (r_state == S_COMMIT) begin
                r_disp <= r_work;
            end
        end
    end

    // Dirty tracking and vblank-edge commit scheduling; a commit missed before vblank falls waits a frame.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            r_dirty       <= 1'b0;
            r_commit_pend <= 1'b0;
            r_vblank_d    <= 1'b0;
        end else begin
            r_vblank_d <= vblank;
            if (r_state == S_COMMIT) begin
                r_dirty <= 1'b0;
            end else if (w_edit_done) begin
                r_dirty <= 1'b1;
            end
            if ((r_state == S_COMMIT) || w_vb_fall) begin
                r_commit_pend <= 1'b0;
            end else if (w_vb_rise && r_dirty) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

    // Outputs are masked while reset is held so an abandoned operation never acks.
    assign board_data   = r_disp;
    assign busy         = rstn & (r_state != S_IDLE);
    assign init_ack     = rstn & w_init_ack;
    assign mv_ack       = rstn & w_mv_ack;
    assign mv_err       = rstn & w_mv_err;
    assign set_ack      = rstn & w_set_ack;
    assign cur_ack      = rstn & w_cur_ack;
    assign commit_pulse = rstn & r_commit_pulse;

endmodule

// File: tb/tb_board_frame_sequencer.sv
// Bench for board_frame_sequencer: table of edits with hand-derived square values,
// hand-written priority and reset sequences, then random edits against a square-list model.
// Stimulus is driven 1 ns after the rising edge and outputs are sampled there too.
module tb_board_frame_sequencer;

    localparam int SQ_W = 12;
    localparam int N_SQ = 64;
    localparam int BW   = SQ_W * N_SQ;

    localparam int OP_INIT = 0;
    localparam int OP_MV   = 1;
    localparam int OP_SET  = 2;
    localparam int OP_CUR  = 3;

    logic          pclk = 1'b0;
    logic          rstn = 1'b0;
    logic          vblank = 1'b0;
    logic          init_req = 1'b0;
    logic          mv_req = 1'b0;
    logic [5:0]    mv_src = '0;
    logic [5:0]    mv_dst = '0;
    logic          set_req = 1'b0;
    logic [5:0]    set_pos = '0;
    logic [4:0]    set_piece = '0;
    logic          cur_req = 1'b0;
    logic          cur_en = 1'b0;
    logic [5:0]    cur_pos = '0;
    logic          cur_color = 1'b0;
    logic [BW-1:0] board_data;
    logic          busy, init_ack, mv_ack, set_ack, cur_ack, mv_err, commit_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: piece code per square, a single cursor location, and the committed board.
    int            m_pc [N_SQ];
    int            m_cur;
    int            m_col;
    bit            m_dirty;
    logic [BW-1:0] m_disp;

    board_frame_sequencer #(.SQ_W(SQ_W), .N_SQ(N_SQ)) dut (
        .pclk(pclk), .rstn(rstn), .vblank(vblank),
        .init_req(init_req),
        .mv_req(mv_req), .mv_src(mv_src), .mv_dst(mv_dst),
        .set_req(set_req), .set_pos(set_pos), .set_piece(set_piece),
        .cur_req(cur_req), .cur_en(cur_en), .cur_pos(cur_pos), .cur_color(cur_color),
        .board_data(board_data), .busy(busy),
        .init_ack(init_ack), .mv_ack(mv_ack), .set_ack(set_ack), .cur_ack(cur_ack),
        .mv_err(mv_err), .commit_pulse(commit_pulse)
    );

    always #5 pclk = ~pclk;

    task automatic chk_i(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_b(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic int fld(input logic [BW-1:0] b, input int s);
        logic [BW-1:0] t;
        t = b >> (s * SQ_W);
        return int'(t[11:0]);
    endfunction

    function automatic int back_type(input int c);
        int t [8] = '{5, 4, 3, 2, 1, 3, 4, 5};
        return t[c];
    endfunction

    task automatic model_init();
        for (int s = 0; s < N_SQ; s++) begin
            int r = s / 8;
            int c = s % 8;
            m_pc[s] = 0;
            if (r == 0)      m_pc[s] = 16 + 8 + back_type(c);
            else if (r == 1) m_pc[s] = 16 + 8 + 6;
            else if (r == 6) m_pc[s] = 16 + 6;
            else if (r == 7) m_pc[s] = 16 + back_type(c);
        end
        m_cur = -1;
        m_col = 0;
    endtask

    function automatic logic [BW-1:0] model_board();
        logic [BW-1:0] b = '0;
        for (int s = 0; s < N_SQ; s++) begin
            int f = m_pc[s];
            if (s == m_cur) f = f + 256 + 512 * m_col;
            b = b | (BW'(f) << (s * SQ_W));
        end
        return b;
    endfunction

    function automatic int model_mv_err(input int src);
        return ((m_pc[src] & 16) == 0) ? 1 : 0;
    endfunction

    task automatic model_apply(input int op, input int a, input int b, input int c);
        case (op)
            OP_INIT: begin model_init(); m_dirty = 1; end
            OP_MV: begin
                if ((m_pc[a] & 16) != 0 && a != b) begin
                    m_pc[b] = m_pc[a];
                    m_pc[a] = 0;
                    m_dirty = 1;
                end
            end
            OP_SET: begin m_pc[a] = b; m_dirty = 1; end
            default: begin
                m_cur   = (b != 0) ? a : -1;
                m_col   = c;
                m_dirty = 1;
            end
        endcase
    endtask

    // Issue one request from an idle cycle, wait (bounded) for its ack, then update the model.
    task automatic do_op(input string name, input int op, input int a, input int b, input int c,
                         output int lat, output int err);
        bit got;
        @(posedge pclk); #1;
        case (op)
            OP_INIT: init_req = 1'b1;
            OP_MV:   begin mv_src = 6'(a); mv_dst = 6'(b); mv_req = 1'b1; end
            OP_SET:  begin set_pos = 6'(a); set_piece = 5'(b); set_req = 1'b1; end
            default: begin cur_pos = 6'(a); cur_en = b[0]; cur_color = c[0]; cur_req = 1'b1; end
        endcase
        lat = 0;
        err = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge pclk); #1;
            lat++;
            case (op)
                OP_INIT: got = init_ack;
                OP_MV:   got = mv_ack;
                OP_SET:  got = set_ack;
                default: got = cur_ack;
            endcase
        end
        err = int'(mv_err);
        init_req = 1'b0; mv_req = 1'b0; set_req = 1'b0; cur_req = 1'b0;
        n_chk++;
        if (got) n_pass++;
        else $display("FAIL %s_ack: no ack within 20 cycles", name);
        if (got) model_apply(op, a, b, c);
    endtask

    // One vblank window: commit expected exactly when the model holds uncommitted edits.
    task automatic frame(input string name);
        int            pulses = 0;
        logic [BW-1:0] exp    = model_board();
        bit            exp_c  = m_dirty;
        @(posedge pclk); #1;
        vblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            if (commit_pulse) begin
                pulses++;
                chk_b({name, "_data"}, board_data, exp);
            end
        end
        vblank = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            if (commit_pulse) pulses++;
        end
        chk_i({name, "_pulses"}, pulses, exp_c ? 1 : 0);
        if (exp_c) begin
            m_disp  = exp;
            m_dirty = 0;
        end
        chk_b({name, "_disp"}, board_data, m_disp);
    endtask

    typedef struct {
        int op;
        int a;
        int b;
        int c;
        int exp_err;
        int exp_lat;
        int probe;
        int probe_val;
    } vec_t;

    initial begin
        vec_t          vt [14];
        int            lat, err;
        string         seq;
        logic [BW-1:0] exp_c;

        vt[0]  = '{OP_MV,   52, 36, 0, 0, 2, 36, 'h016};
        vt[1]  = '{OP_MV,   27, 20, 0, 1, 1, 52, 'h000};
        vt[2]  = '{OP_CUR,  10,  1, 1, 0, 1, 10, 'h31E};
        vt[3]  = '{OP_CUR,  11,  1, 0, 0, 1, 10, 'h01E};
        vt[4]  = '{OP_MV,    4,  4, 0, 0, 1, 11, 'h11E};
        vt[5]  = '{OP_SET,  27, 26, 0, 0, 1, 27, 'h01A};
        vt[6]  = '{OP_CUR,   0,  0, 0, 0, 1, 11, 'h01E};
        vt[7]  = '{OP_MV,   11, 27, 0, 0, 2, 27, 'h01E};
        vt[8]  = '{OP_CUR,  27,  1, 1, 0, 1, 27, 'h31E};
        vt[9]  = '{OP_MV,   27, 35, 0, 0, 2, 27, 'h300};
        vt[10] = '{OP_CUR,  27,  1, 0, 0, 1, 27, 'h100};
        vt[11] = '{OP_INIT,  0,  0, 0, 0, 1, 27, 'h000};
        vt[12] = '{OP_MV,    0, 63, 0, 0, 2, 63, 'h01D};
        vt[13] = '{OP_SET,  63,  0, 0, 0, 1, 63, 'h000};

        // Reset state.
        repeat (3) @(posedge pclk);
        #1;
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_acks", int'({init_ack, mv_ack, set_ack, cur_ack, mv_err, commit_pulse}), 0);
        rstn = 1'b1;
        model_init();
        m_dirty = 0;
        m_disp  = model_board();
        chk_b("rst_board", board_data, m_disp);
        chk_i("rst_sq4", fld(board_data, 4), 'h019);
        chk_i("rst_sq60", fld(board_data, 60), 'h011);
        chk_i("rst_sq27", fld(board_data, 27), 'h000);
        frame("rst_frame");

        // Table of single edits, each followed by a frame.
        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].c, lat, err);
            chk_i($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            if (vt[i].op == OP_MV) chk_i($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            chk_b($sformatf("vec%0d_hold", i), board_data, m_disp);
            frame($sformatf("vec%0d_frame", i));
            chk_i($sformatf("vec%0d_probe", i), fld(board_data, vt[i].probe), vt[i].probe_val);
        end

        // Simultaneous requests just after a dirty vblank rise: commit, move, set, cursor.
        do_op("pre_set", OP_SET, 40, 18, 0, lat, err);
        exp_c = model_board();
        @(posedge pclk); #1;
        vblank = 1'b1;
        @(posedge pclk); #1;
        mv_src = 6'd57; mv_dst = 6'd42; mv_req = 1'b1;
        set_pos = 6'd41; set_piece = 5'd28; set_req = 1'b1;
        cur_pos = 6'd30; cur_en = 1'b1; cur_color = 1'b1; cur_req = 1'b1;
        seq = "";
        for (int i = 0; i < 20; i++) begin
            @(posedge pclk); #1;
            if (commit_pulse) begin
                seq = {seq, "C"};
                chk_b("prio_commit_data", board_data, exp_c);
                m_disp  = exp_c;
                m_dirty = 0;
            end
            if (mv_ack)  begin seq = {seq, "M"}; mv_req  = 1'b0; model_apply(OP_MV, 57, 42, 0); end
            if (set_ack) begin seq = {seq, "S"}; set_req = 1'b0; model_apply(OP_SET, 41, 28, 0); end
            if (cur_ack) begin seq = {seq, "U"}; cur_req = 1'b0; model_apply(OP_CUR, 30, 1, 1); end
        end
        mv_req = 1'b0; set_req = 1'b0; cur_req = 1'b0;
        n_chk++;
        if (seq == "CMSU") n_pass++;
        else $display("FAIL prio_order: got %s expected CMSU", seq);
        @(posedge pclk); #1;
        vblank = 1'b0;
        @(posedge pclk); #1;
        chk_b("prio_hold", board_data, m_disp);
        frame("prio_second_commit");

        // Reset while a move is in its write cycle.
        @(posedge pclk); #1;
        mv_src = 6'd62; mv_dst = 6'd45; mv_req = 1'b1;
        @(posedge pclk); #1;
        chk_i("rmv_busy_chk", int'(busy), 1);
        @(posedge pclk); #1;
        rstn = 1'b0;
        #1;
        chk_i("rmv_no_ack", int'(mv_ack), 0);
        @(posedge pclk); #1;
        mv_req = 1'b0;
        model_init();
        m_dirty = 0;
        m_disp  = model_board();
        chk_b("rmv_board", board_data, m_disp);
        chk_i("rmv_busy", int'(busy), 0);
        @(posedge pclk); #1;
        rstn = 1'b1;
        frame("rmv_frame");
        do_op("rmv_set", OP_SET, 45, 22, 0, lat, err);
        frame("rmv_work_frame");

        // Random edits against the model.
        for (int i = 0; i < 60; i++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 5) begin
                int src = $urandom_range(0, 63);
                int dst = ($urandom_range(0, 7) == 0) ? src : $urandom_range(0, 63);
                int e, l;
                for (int t = 0; t < 8 && $urandom_range(0, 3) != 0 && (m_pc[src] & 16) == 0; t++)
                    src = $urandom_range(0, 63);
                e = model_mv_err(src);
                l = (e == 1 || src == dst) ? 1 : 2;
                do_op($sformatf("rnd%0d_mv", i), OP_MV, src, dst, 0, lat, err);
                chk_i($sformatf("rnd%0d_err", i), err, e);
                chk_i($sformatf("rnd%0d_lat", i), lat, l);
            end else if (sel < 7) begin
                do_op($sformatf("rnd%0d_set", i), OP_SET, $urandom_range(0, 63), $urandom_range(0, 31), 0, lat, err);
                chk_i($sformatf("rnd%0d_lat", i), lat, 1);
            end else if (sel < 9) begin
                do_op($sformatf("rnd%0d_cur", i), OP_CUR, $urandom_range(0, 63),
                      ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1), lat, err);
                chk_i($sformatf("rnd%0d_lat", i), lat, 1);
            end else begin
                do_op($sformatf("rnd%0d_init", i), OP_INIT, 0, 0, 0, lat, err);
                chk_i($sformatf("rnd%0d_lat", i), lat, 1);
            end
            chk_b($sformatf("rnd%0d_hold", i), board_data, m_disp);
            if ($urandom_range(0, 2) == 0) frame($sformatf("rnd%0d_frame", i));
        end
        frame("final_frame");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
